// File: rtl/packet_builder.sv
// Transmit-side packet serializer: header words (length/stream, sequence) then payload,
// with a per-stream sequence counter advanced only when a packet completes.
module packet_builder #(
  parameter int unsigned NUM_STREAMS       = 32,
  parameter int unsigned MAX_PAYLOAD_BYTES = 37
) (
  input  logic                             clk,
  input  logic                             reset_b,
  input  logic [0:8*MAX_PAYLOAD_BYTES-1]   dataIn,
  input  logic [5:0]                       dataIn_len,
  input  logic [15:0]                      dataIn_stream,
  input  logic                             dataIn_val,
  output logic                             dataIn_ready,
  output logic                             dataIn_err,
  output logic [31:0]                      dataOut,
  output logic                             dataOut_val,
  input  logic                             dataOut_ready,
  output logic                             dataOut_last
);

  localparam int unsigned IDX_W     = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam int unsigned MAX_WORDS = (MAX_PAYLOAD_BYTES + 3) / 4;
  localparam int unsigned PAY_W     = 32 * MAX_WORDS;
  localparam int unsigned WIDX_W    = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} stateT;

  stateT              stateQ, stateD;
  logic [0:PAY_W-1]   payQ, maskedPay;
  logic [15:0]        streamQ;
  logic [31:0]        seqQ, seqNext;
  logic [IDX_W-1:0]   idxQ;
  logic [WIDX_W-1:0]  wordQ, wordD, nextWord, lastWordQ, lastWordIn;
  logic [31:0]        seqCnt [NUM_STREAMS];
  logic [31:0]        outD;
  logic [15:0]        totLen;
  logic               valD, lastD, readyD, errD;
  logic               legal, capture, commit;

  assign legal      = (dataIn_len != 6'd0) && (int'(dataIn_len) <= int'(MAX_PAYLOAD_BYTES));
  assign seqNext    = seqCnt[dataIn_stream[IDX_W-1:0]] + 32'd1;
  assign lastWordIn = WIDX_W'((int'(dataIn_len) + 3) / 4 - 1);
  assign totLen     = 16'(dataIn_len) + 16'd8;
  assign nextWord   = wordQ + WIDX_W'(1);

  // Zero every byte at or beyond the requested length so padding bytes go out as 0.
  always_comb begin
    maskedPay = '0;
    for (int k = 0; k < int'(MAX_PAYLOAD_BYTES); k++) begin
      if (k < int'(dataIn_len)) maskedPay[8*k +: 8] = dataIn[8*k +: 8];
    end
  end

  always_comb begin
    stateD  = stateQ;
    outD    = dataOut;
    valD    = dataOut_val;
    lastD   = dataOut_last;
    readyD  = dataIn_ready;
    errD    = 1'b0;
    wordD   = wordQ;
    capture = 1'b0;
    commit  = 1'b0;
    case (stateQ)
      IDLE: begin
        readyD = 1'b1;
        valD   = 1'b0;
        lastD  = 1'b0;
        if (dataIn_val && dataIn_ready) begin
          if (legal) begin
            capture = 1'b1;
            stateD  = HDR0;
            readyD  = 1'b0;
            valD    = 1'b1;
            outD    = {totLen[7:0], totLen[15:8], dataIn_stream[7:0], dataIn_stream[15:8]};
          end else begin
            errD = 1'b1;
          end
        end
      end
      HDR0: begin
        if (dataOut_ready) begin
          stateD = HDR1;
          outD   = {seqQ[7:0], seqQ[15:8], seqQ[23:16], seqQ[31:24]};
        end
      end
      HDR1: begin
        if (dataOut_ready) begin
          stateD = DATA;
          wordD  = '0;
          outD   = payQ[0 +: 32];
          lastD  = (lastWordQ == '0);
        end
      end
      DATA: begin
        if (dataOut_ready) begin
          if (dataOut_last) begin
            commit = 1'b1;
            stateD = IDLE;
            valD   = 1'b0;
            lastD  = 1'b0;
            readyD = 1'b1;
            outD   = '0;
          end else begin
            wordD = nextWord;
            outD  = payQ[32*int'(nextWord) +: 32];
            lastD = (nextWord == lastWordQ);
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      stateQ       <= IDLE;
      dataOut      <= '0;
      dataOut_val  <= 1'b0;
      dataOut_last <= 1'b0;
      dataIn_ready <= 1'b0;
      dataIn_err   <= 1'b0;
      wordQ        <= '0;
    end else begin
      stateQ       <= stateD;
      dataOut      <= outD;
      dataOut_val  <= valD;
      dataOut_last <= lastD;
      dataIn_ready <= readyD;
      dataIn_err   <= errD;
      wordQ        <= wordD;
    end
  end

  // Request capture: payload, stream and the sequence number this packet will carry.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      payQ      <= '0;
      streamQ   <= '0;
      seqQ      <= '0;
      idxQ      <= '0;
      lastWordQ <= '0;
    end else if (capture) begin
      payQ      <= maskedPay;
      streamQ   <= dataIn_stream;
      seqQ      <= seqNext;
      idxQ      <= dataIn_stream[IDX_W-1:0];
      lastWordQ <= lastWordIn;
    end
  end

  // Counters advance only on last-word transfer, so an abandoned packet never consumes a number.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < int'(NUM_STREAMS); i++) seqCnt[i] <= '0;
    end else if (commit) begin
      seqCnt[idxQ] <= seqQ;
    end
  end

endmodule

// File: doc/packet_builder.md
Name: packet_builder

Overview:
- Transmit-side counterpart of the stream packet parser.
- Accepts one payload of up to 37 bytes plus a stream ID and payload length on a parallel interface.
- Assigns a per-stream 32-bit sequence number and serializes the packet as 32-bit words with valid/ready/last framing.
- Output word format is exactly the format the parser consumes: two header words, then payload.

Parameters:
- NUM_STREAMS, 32, number of per-stream sequence counters; indexed by dataIn_stream[log2(NUM_STREAMS)-1:0].
- MAX_PAYLOAD_BYTES, 37, largest legal payload length; payload bus width is 8*MAX_PAYLOAD_BYTES.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset_b  input  1  reset, asynchronous assert, active-low.
- dataIn  input  [0:295]  payload; byte k at bits [8k:8k+7].
- dataIn_len  input  6  payload length in bytes; legal range 1..37.
- dataIn_stream  input  16  stream ID.
- dataIn_val  input  1  payload request valid.
- dataIn_ready  output  1  block can accept a request.
- dataIn_err  output  1  one-cycle pulse when an illegal-length request is accepted.
- dataOut  output  32  serialized word.
- dataOut_val  output  1  dataOut valid.
- dataOut_ready  input  1  downstream accepts word.
- dataOut_last  output  1  marks the final word of the packet.

Behaviour:
- Reset (reset_b low, takes effect immediately, also mid-packet):
  - state IDLE; all sequence counters cleared to 0.
  - dataOut_val=0, dataOut_last=0, dataOut=0, dataIn_err=0.
  - dataIn_ready=0 while reset_b is low; dataIn_ready=1 from the first clock after deassertion.
  - A partial packet in flight is abandoned and never resumed.
- States: IDLE, HDR0, HDR1, DATA.
- IDLE:
  - dataIn_ready=1.
  - On dataIn_val&&dataIn_ready, capture payload, len, stream.
  - If len is 1..37: compute seq = counter[stream idx]+1 (32-bit wrap, 0xFFFFFFFF+1=0) and go to HDR0.
  - If len is 0 or >37: pulse dataIn_err the next cycle, stay IDLE, emit nothing, leave the counter unchanged.
- dataIn_ready=0 in HDR0, HDR1 and DATA.
- Word transfer rule:
  - A word transfers on a cycle with dataOut_val&&dataOut_ready.
  - While dataOut_val=1 and dataOut_ready=0, dataOut and dataOut_last hold stable.
  - dataOut_val is 1 in HDR0, HDR1 and DATA; 0 in IDLE.
- HDR0 word, with T = len+8 as 16 bits:
  - dataOut[31:24]=T[7:0], [23:16]=T[15:8].
  - [15:8]=stream[7:0], [7:0]=stream[15:8].
  - On transfer go to HDR1.
- HDR1 word:
  - dataOut[31:24]=seq[7:0], [23:16]=seq[15:8], [15:8]=seq[23:16], [7:0]=seq[31:24].
  - On transfer go to DATA; word index w=0.
- DATA:
  - Number of payload words N = ceil(len/4), range 1..10.
  - Word w: dataOut[31:24]=payload byte 4w, [23:16]=byte 4w+1, [15:8]=byte 4w+2, [7:0]=byte 4w+3.
  - Bytes at index >= len are driven 0.
  - dataOut_last=1 only on word N-1; 0 on header words and all other words.
  - On transfer of a non-last word: w increments.
  - On transfer of the last word: write counter[stream idx]=seq, go to IDLE.
- Timing:
  - First header word valid in the cycle after request acceptance.
  - Next request can be accepted in the cycle after the last word transfers.
  - Minimum packet occupancy is N+3 cycles.
- Stream table:
  - Only the low log2(NUM_STREAMS) bits of the stream ID index the counter table.
  - The full 16-bit stream ID is transmitted unchanged.
  - Stream IDs that alias to the same index share one counter.
- Counter update: occurs only on last-word transfer, so an abandoned packet (reset) never advances the sequence.

Test Plan:
- Basic packet:
  - Stimulus: stream 0x0102, len 5, payload bytes A0 A1 A2 A3 A4, dataOut_ready=1 throughout.
  - Required: words 0x0D000201, 0x01000000, 0xA0A1A2A3, 0xA4000000; last=1 on the 4th word only.
  - Required: dataIn_ready returns to 1 in the cycle after the 4th word.
- Max length:
  - Stimulus: len 37 on stream 3.
  - Required: HDR0=0x2D000300, then 10 payload words; 10th word is byte36 followed by 0x000000, with last=1.
- Sequence tracking:
  - Stimulus: three packets on stream 5, one on stream 0x0025.
  - Required: seq words 0x01000000, 0x02000000, 0x03000000, then 0x04000000 for stream 0x0025 (aliases to index 5).
- Backpressure:
  - Stimulus: hold dataOut_ready=0 for 3 cycles on every word, with random stalls.
  - Required: each word held stable; no word dropped or duplicated; dataIn_ready stays 0 until the final word transfers.
- Illegal length:
  - Stimulus: len 0, then len 40.
  - Required: each request accepted, dataIn_err pulses one cycle, no dataOut_val.
  - Required: the next legal packet on that stream carries seq 1.
- Reset mid-packet:
  - Stimulus: assert reset_b=0 during DATA of a stream-2 packet.
  - Required: dataOut_val drops immediately; after reset the next stream-2 packet carries seq 0x01000000.
